// File: rtl/dmem_ecc_scrubber.sv
// Walks every dmem word after load, decodes 39-bit Hamming SECDED, reports faulty words.
// Optional SCRUB_WRITEBACK_EN: single-bit errors are written back corrected.
module dmem_ecc_scrubber #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              mem_req_o,
  input  logic              mem_gnt_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [38:0]       mem_rdata_i,
  output logic              mem_we_o,
  output logic [38:0]       mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_valid_o,
  output logic [ADDR_W-1:0] err_addr_o,
  output logic [38:0]       err_raw_o,
  output logic [31:0]       err_data_o,
  output logic              err_double_o,
  output logic [CNT_W-1:0]  sec_count_o,
  output logic [CNT_W-1:0]  ded_count_o
);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_CHK, S_WB, S_NEXT, S_FIN} state_e;

  // Positions 1..38 whose index has syndrome bit b set.
  localparam logic [38:0] M0 = 39'h2AAAAAAAAA;
  localparam logic [38:0] M1 = 39'h4CCCCCCCCC;
  localparam logic [38:0] M2 = 39'h70F0F0F0F0;
  localparam logic [38:0] M3 = 39'h00FF00FF00;
  localparam logic [38:0] M4 = 39'h00FFFF0000;
  localparam logic [38:0] M5 = 39'h7F00000000;

  function automatic logic [31:0] data_of(input logic [38:0] cw);
    data_of = {cw[38:33], cw[31:17], cw[15:9], cw[7:5], cw[3]};
  endfunction

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [38:0]        raw_q, raw_d;
  logic               err_valid_q, err_valid_d;
  logic [ADDR_W-1:0]  err_addr_q, err_addr_d;
  logic [38:0]        err_raw_q, err_raw_d;
  logic [31:0]        err_data_q, err_data_d;
  logic               err_double_q, err_double_d;
  logic [CNT_W-1:0]   sec_q, sec_d, ded_q, ded_d;
`ifdef SCRUB_WRITEBACK_EN
  logic [38:0]        wdata_q, wdata_d;
`endif

  logic [5:0]  syn;
  logic        par, single, dbl;
  logic [38:0] fixed;

  always_comb begin
    syn    = {^(raw_q & M5), ^(raw_q & M4), ^(raw_q & M3),
              ^(raw_q & M2), ^(raw_q & M1), ^(raw_q & M0)};
    par    = ^raw_q;
    single = par && (syn <= 6'd38);
    dbl    = (par && (syn > 6'd38)) || (!par && (syn != 6'd0));
    fixed  = single ? (raw_q ^ ({38'd0, 1'b1} << syn)) : raw_q;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      raw_q        <= '0;
      err_valid_q  <= 1'b0;
      err_addr_q   <= '0;
      err_raw_q    <= '0;
      err_data_q   <= '0;
      err_double_q <= 1'b0;
      sec_q        <= '0;
      ded_q        <= '0;
`ifdef SCRUB_WRITEBACK_EN
      wdata_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      raw_q        <= raw_d;
      err_valid_q  <= err_valid_d;
      err_addr_q   <= err_addr_d;
      err_raw_q    <= err_raw_d;
      err_data_q   <= err_data_d;
      err_double_q <= err_double_d;
      sec_q        <= sec_d;
      ded_q        <= ded_d;
`ifdef SCRUB_WRITEBACK_EN
      wdata_q      <= wdata_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    raw_d        = raw_q;
    err_valid_d  = 1'b0;
    err_addr_d   = err_addr_q;
    err_raw_d    = err_raw_q;
    err_data_d   = err_data_q;
    err_double_d = err_double_q;
    sec_d        = sec_q;
    ded_d        = ded_q;
`ifdef SCRUB_WRITEBACK_EN
    wdata_d      = wdata_q;
`endif
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    case (state_q)
      S_IDLE: if (start_i) begin
        addr_d  = '0;
        sec_d   = '0;
        ded_d   = '0;
        state_d = S_RD;
      end
      S_RD: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) state_d = S_CAP;
      end
      S_CAP: begin
        raw_d   = mem_rdata_i;
        state_d = S_CHK;
      end
      S_CHK: begin
        state_d = S_NEXT;
        if (single || dbl) begin
          err_valid_d  = 1'b1;
          err_addr_d   = addr_q;
          err_raw_d    = raw_q;
          err_data_d   = data_of(fixed);
          err_double_d = dbl;
        end
        if (single && (sec_q != '1)) sec_d = sec_q + 1'b1;
        if (dbl && (ded_q != '1))    ded_d = ded_q + 1'b1;
`ifdef SCRUB_WRITEBACK_EN
        wdata_d = fixed;
        if (single) state_d = S_WB;
`endif
      end
      S_WB: begin
`ifdef SCRUB_WRITEBACK_EN
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
        if (mem_gnt_i) state_d = S_NEXT;
`else
        state_d = S_NEXT;
`endif
      end
      S_NEXT: begin
        if (addr_q == ADDR_W'(DEPTH - 1)) state_d = S_FIN;
        else begin
          addr_d  = addr_q + 1'b1;
          state_d = S_RD;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

`ifdef SCRUB_WRITEBACK_EN
  assign mem_wdata_o = wdata_q;
`else
  assign mem_wdata_o = '0;
`endif
  assign mem_addr_o   = addr_q;
  assign busy_o       = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done_o       = (state_q == S_FIN);
  assign err_valid_o  = err_valid_q;
  assign err_addr_o   = err_addr_q;
  assign err_raw_o    = err_raw_q;
  assign err_data_o   = err_data_q;
  assign err_double_o = err_double_q;
  assign sec_count_o  = sec_q;
  assign ded_count_o  = ded_q;

endmodule

// File: tb/tb_dmem_ecc_scrubber.sv
// Scoreboard bench for dmem_ecc_scrubber: memory model, grant control, err-report monitor.
module tb_dmem_ecc_scrubber;
  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int CW    = 8;
`ifdef SCRUB_WRITEBACK_EN
  localparam int WBC = 1;
`else
  localparam int WBC = 0;
`endif
  localparam logic [38:0] CLEAN = 39'h00000000CC;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic mem_req, mem_we, busy, done, err_valid, err_double;
  logic mem_gnt = 1'b1;
  logic [AW-1:0] mem_addr, err_addr;
  logic [38:0] mem_rdata = '0;
  logic [38:0] mem_wdata, err_raw;
  logic [31:0] err_data;
  logic [CW-1:0] sec_count, ded_count;

  always #5 clk = ~clk;

  dmem_ecc_scrubber #(.DEPTH(DEPTH), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start),
    .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr),
    .mem_rdata_i(mem_rdata), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .busy_o(busy), .done_o(done), .err_valid_o(err_valid), .err_addr_o(err_addr),
    .err_raw_o(err_raw), .err_data_o(err_data), .err_double_o(err_double),
    .sec_count_o(sec_count), .ded_count_o(ded_count));

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [38:0]   raw;
    logic [31:0]   data;
    logic          dbl;
  } err_t;

  err_t sb[$];
  int checks = 0, failures = 0;
  int done_cnt = 0, we_seen = 0, stall_left = 0;
  bit stall_on = 0, wb_hold = 0;

  // Memory: 1-cycle read latency, writes on granted mem_we, bulk preload port.
  logic [38:0] mem [DEPTH];
  logic        pl_go = 1'b0;
  logic [38:0] pl_val = '0, pl_bad = '0;
  logic [AW-1:0] pl_addr = '0;
  always @(posedge clk) begin
    if (pl_go) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= (i == int'(pl_addr)) ? pl_bad : pl_val;
    end else if (mem_req && mem_gnt) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Grant for the coming edge is decided at the negedge; also pops err reports.
  task automatic monitor();
    err_t e;
    logic g;
    forever begin
      @(negedge clk);
      g = 1'b1;
      if (stall_left > 0 && (stall_on || (mem_req && mem_addr == 5'd4))) begin
        if (stall_on) chk("stall_hold", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 5'd4});
        stall_on = 1;
        stall_left--;
        g = 1'b0;
      end else stall_on = 0;
      if (wb_hold && mem_we) g = 1'b0;
      mem_gnt = g;
      if (mem_we) we_seen++;
      if (done) done_cnt++;
      if (err_valid) begin
        if (sb.size() == 0) chk("err_unexpected", {32'd0, 27'd0, err_addr}, 64'hFFFF);
        else begin
          e = sb.pop_front();
          chk("err_addr",   64'(err_addr),   64'(e.addr));
          chk("err_raw",    64'(err_raw),    64'(e.raw));
          chk("err_data",   64'(err_data),   64'(e.data));
          chk("err_double", 64'(err_double), 64'(e.dbl));
        end
      end
    end
  endtask

  task automatic preload(input logic [38:0] v, input int a, input logic [38:0] bad);
    @(negedge clk);
    pl_val = v; pl_addr = a[AW-1:0]; pl_bad = bad; pl_go = 1'b1;
    @(negedge clk);
    pl_go = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ctl"}, {32'd0, mem_req, mem_we, busy, done, err_valid, err_double,
                        mem_addr, err_addr, sec_count, ded_count}, 64'd0);
    chk({tag, "_raw"}, 64'(err_raw), 64'd0);
    chk({tag, "_data"}, {32'd0, err_data}, 64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
  endtask

  task automatic scan(input int exp_cyc, input int exp_sec, input int exp_ded, input bit repulse);
    int n, d0;
    d0 = done_cnt;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    n = 0;
    while (!done && n < 4000) begin
      @(posedge clk); #1;
      n++;
      start = (repulse && n == 20);
    end
    start = 1'b0;
    chk("scan_cycles", 64'(n), 64'(exp_cyc));
    chk("busy_at_done", 64'(busy), 64'd0);
    chk("sec_count", 64'(sec_count), 64'(exp_sec));
    chk("ded_count", 64'(ded_count), 64'(exp_ded));
    repeat (5) @(posedge clk);
    #1;
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
    chk("counts_hold", {48'd0, sec_count, ded_count}, {48'd0, 8'(exp_sec), 8'(exp_ded)});
    chk("sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int n, w0;
    fork monitor(); join_none
    #1 rst = 1'b1;
    preload(CLEAN, 0, CLEAN);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // 1: all clean
    scan(128, 0, 0, 0);

    // 2: single error at addr 1, bit 6
    preload(CLEAN, 1, 39'h8C);
    sb.push_back('{addr: 5'd1, raw: 39'h8C, data: 32'd13, dbl: 1'b0});
    scan(128 + WBC, 1, 0, 0);
`ifdef SCRUB_WRITEBACK_EN
    chk("wb_mem1", 64'(mem[1]), 64'(CLEAN));
    scan(128, 0, 0, 0);
`else
    chk("ro_mem1", 64'(mem[1]), 64'h8C);
`endif

    // 3: double error (bits 5,6) -> raw data bits 0b1011, never written
    preload(CLEAN, 1, 39'hAC);
    sb.push_back('{addr: 5'd1, raw: 39'hAC, data: 32'd11, dbl: 1'b1});
    w0 = we_seen;
    scan(128, 0, 1, 0);
    chk("ded_no_we", 64'(we_seen - w0), 64'd0);
    chk("ded_mem1", 64'(mem[1]), 64'hAC);

    // 4: 10 ungranted edges on addr 4
    preload(CLEAN, 0, CLEAN);
    stall_left = 10;
    scan(138, 0, 0, 0);

    // 5: reset in the middle of a scan (during write-back when enabled)
    preload(CLEAN, 1, 39'h8C);
    sb.push_back('{addr: 5'd1, raw: 39'h8C, data: 32'd13, dbl: 1'b0});
    wb_hold = 1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
`ifdef SCRUB_WRITEBACK_EN
    while (!mem_we && n < 400) begin @(negedge clk); n++; end
    chk("wb_reached", 64'(mem_we), 64'd1);
`else
    while (mem_addr != 5'd5 && n < 400) begin @(negedge clk); n++; end
    chk("mid_reached", 64'(mem_addr), 64'd5);
`endif
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    chk("midrst_mem1", 64'(mem[1]), 64'h8C);
    @(negedge clk);
    rst = 1'b0;
    wb_hold = 0;
    sb.push_back('{addr: 5'd1, raw: 39'h8C, data: 32'd13, dbl: 1'b0});
    scan(128 + WBC, 1, 0, 0);

    // 6: start re-pulsed while busy; overall-parity bit flip at addr 3
    preload(CLEAN, 3, 39'hCD);
    sb.push_back('{addr: 5'd3, raw: 39'hCD, data: 32'd13, dbl: 1'b0});
    scan(128 + WBC, 1, 0, 1);
`ifdef SCRUB_WRITEBACK_EN
    chk("wb_mem3", 64'(mem[3]), 64'(CLEAN));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
